// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and the iteration counter width helper.
package muldiv_pkg;

   localparam int unsigned MULDIV_WIDTH = 32;

   // op field encodings from the EX stage
   localparam logic [1:0] MULDIV_MULT  = 2'b00;
   localparam logic [1:0] MULDIV_MULTU = 2'b01;
   localparam logic [1:0] MULDIV_DIV   = 2'b10;
   localparam logic [1:0] MULDIV_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2
   } state_e;

   // Counter must be able to represent 0..w
   function automatic int unsigned muldiv_cnt_w(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   i_is_div  1       select compare-subtract-shift (1) or add-shift (0)
//   i_acc     2*W     current accumulator {upper, lower}
//   i_opnd    W       multiplicand (mul) or divisor (div) magnitude
//   o_acc     2*W     accumulator after one iteration
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MULDIV_WIDTH
) (
   input  logic                 i_is_div,
   input  logic [2*WIDTH-1:0]   i_acc,
   input  logic [WIDTH-1:0]     i_opnd,
   output logic [2*WIDTH-1:0]   o_acc
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;

   // Multiply: conditionally add multiplicand to upper half, then shift right
   // with the carry. Divide: shift {rem, dividend} left one bit and subtract
   // the divisor from the (WIDTH+1)-bit partial remainder when it fits.
   always_comb begin
      w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
      w_diff = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opnd};
      if (!i_is_div) begin
         o_acc = {w_sum, i_acc[WIDTH-1:1]};
      end else if (!w_diff[WIDTH]) begin
         o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      end else begin
         o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit with HI/LO registers for the EX stage.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op         accept an operation (op: mult/multu/div/divu)
//   rs_val, rt_val    multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata direct HI/LO writes when idle
//   busy              start OR unit occupied (combinational, to hazard unit)
//   done              one-cycle pulse when HI/LO hold a new result
//   hi, lo            HI/LO registers
//   div_by_zero       last divide had a zero divisor; cleared on next start
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MULDIV_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [WIDTH-1:0]  rs_val,
   input  logic [WIDTH-1:0]  rt_val,
   input  logic              mthi,
   input  logic              mtlo,
   input  logic [WIDTH-1:0]  wdata,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  hi,
   output logic [WIDTH-1:0]  lo,
   output logic              div_by_zero
);

   localparam int unsigned CNT_W = muldiv_cnt_w(WIDTH);

   state_e             r_state;
   state_e             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] w_step_acc;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   w_rs_mag;
   logic [WIDTH-1:0]   w_rt_mag;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic               r_is_div;
   logic               r_neg_res;
   logic               r_neg_rem;
   logic               r_dbz_pend;
   logic               w_is_div;
   logic               w_is_signed;
   logic               w_accept;
   logic               w_wb;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;
   logic               r_dbz;

   // Operand decode and two's-complement magnitudes for signed ops
   always_comb begin
      w_is_div    = !((op == MULDIV_MULT) || (op == MULDIV_MULTU));
      w_is_signed = (op == MULDIV_MULT) || (op == MULDIV_DIV);
      w_rs_mag    = (w_is_signed && rs_val[WIDTH-1]) ? (~rs_val + WIDTH'(1)) : rs_val;
      w_rt_mag    = (w_is_signed && rt_val[WIDTH-1]) ? (~rt_val + WIDTH'(1)) : rt_val;
   end

   // Next-state logic
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_wb     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = ST_CALC;
            end
         end
         ST_CALC: begin
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
               w_next = ST_FIXUP;
            end
         end
         ST_FIXUP: begin
            w_wb   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div (r_is_div),
      .i_acc    (r_acc),
      .i_opnd   (r_opnd),
      .o_acc    (w_step_acc)
   );

   // Iteration datapath: operand capture on accept, one step per CALC cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_acc      <= '0;
         r_opnd     <= '0;
         r_is_div   <= 1'b0;
         r_neg_res  <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_dbz_pend <= 1'b0;
      end else if (w_accept) begin
         r_cnt      <= '0;
         r_is_div   <= w_is_div;
         r_acc      <= {WIDTH'(0), (w_is_div ? w_rs_mag : w_rt_mag)};
         r_opnd     <= w_is_div ? w_rt_mag : w_rs_mag;
         r_neg_res  <= w_is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
         r_neg_rem  <= w_is_signed && w_is_div && rs_val[WIDTH-1];
         r_dbz_pend <= w_is_div && (rt_val == '0);
      end else if (r_state == ST_CALC) begin
         r_acc <= w_step_acc;
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Sign fix-up of the magnitude result. A zero divisor leaves the dividend
   // magnitude in the remainder, so restoring its sign returns rs_val intact.
   always_comb begin
      w_prod = r_neg_res ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
      w_quo  = r_neg_res ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
      w_rem  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : r_acc[2*WIDTH-1:WIDTH];
   end

   // HI/LO, done and div_by_zero registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_wb) begin
            r_done <= 1'b1;
            if (r_is_div) begin
               r_hi  <= w_rem;
               r_lo  <= r_dbz_pend ? '1 : w_quo;
               r_dbz <= r_dbz_pend;
            end else begin
               r_hi  <= w_prod[2*WIDTH-1:WIDTH];
               r_lo  <= w_prod[WIDTH-1:0];
               r_dbz <= 1'b0;
            end
         end else if (w_accept) begin
            r_dbz <= 1'b0;
         end else if (r_state == ST_IDLE) begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
         end
      end
   end

   assign busy        = start || (r_state != ST_IDLE);
   assign done        = r_done;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes hand-computed HI/LO/dbz
// expectations, a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .mthi        (mthi),
      .mtlo        (mtlo),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: compare every done pulse against the oldest expectation
   always @(negedge clk) begin
      if (!rst && done) begin
         chk("done_while_busy", 32'(busy), 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0 hi=%h lo=%h", hi, lo);
         end else begin
            mon_e = exp_q.pop_front();
            chk("hi", hi, mon_e.hi);
            chk("lo", lo, mon_e.lo);
            chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
         end
      end
   end

   // Issue one op; optionally inject mthi (kind 1) or a stray start (kind 2)
   // at busy cycle inj_cyc; optionally check latency and busy window.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed,
                         input int inj_cyc, input int inj_kind, input bit chk_lat);
      int n;
      int busy_cnt;
      bit got;
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      exp_q.push_back('{hi: eh, lo: el, dbz: ed});
      #1;
      chk("busy_start_cycle", 32'(busy), 32'd1);
      n        = 0;
      busy_cnt = 0;
      got      = 1'b0;
      while (n < 40 && !got) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            start  = 1'b0;
            rs_val = ~a;
            rt_val = ~b;
         end
         if (n == inj_cyc + 1) begin
            mthi  = 1'b0;
            start = 1'b0;
         end
         #1;
         if (done) begin
            got = 1'b1;
         end else begin
            if (busy) busy_cnt++;
            if (n == inj_cyc && inj_kind == 1) begin
               mthi  = 1'b1;
               wdata = 32'hDEAD_BEEF;
            end
            if (n == inj_cyc && inj_kind == 2) begin
               start  = 1'b1;
               op     = 2'b11;
               rs_val = 32'd9;
               rt_val = 32'd3;
            end
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_done required=done_within_40");
      end else if (chk_lat) begin
         chk("latency", 32'(n), 32'd34);
         chk("busy_cycles", 32'(busy_cnt), 32'd33);
         chk("busy_at_done", 32'(busy), 32'd0);
      end
      @(negedge clk);
      start = 1'b0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
   endtask

   initial begin
      bit saw_done;
      rst    = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      rs_val = '0;
      rt_val = '0;
      mthi   = 1'b0;
      mtlo   = 1'b0;
      wdata  = '0;
      repeat (3) @(negedge clk);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // mtlo in IDLE
      mtlo  = 1'b1;
      wdata = 32'h0000_1234;
      @(negedge clk);
      mtlo = 1'b0;
      chk("mtlo_lo", lo, 32'h0000_1234);
      chk("mtlo_hi_kept", hi, 32'd0);
      @(negedge clk);

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0, 1);
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0, 0);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0, 0, 0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0, 0);
      run_op(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 0, 0, 0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 0, 0, 0);
      run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("dbz_sticky", 32'(div_by_zero), 32'd1);
      // mthi during busy must be dropped
      run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 3, 1, 0);
      // stray start mid-operation must be ignored
      run_op(2'b01, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0, 5, 2, 0);

      // reset at cycle 10 of a divide aborts without writeback
      start  = 1'b1;
      op     = 2'b11;
      rs_val = 32'd100;
      rt_val = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("abort_no_done", 32'(saw_done), 32'd0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0, 1);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
